// File: rtl/cmp_pkg.sv
// Shared types and constants for the compare window tracker.
package cmp_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } cmp_state_t;

  localparam logic [DATA_W-1:0] MIN_INIT = 4'hF;
  localparam logic [DATA_W-1:0] MAX_INIT = 4'h0;

  typedef enum logic [2:0] {
    HI = 3'b100,
    EQ = 3'b010,
    LO = 3'b001
  } cmp_class_t;

endpackage

// File: rtl/cmp_classify.sv
// Combinational unsigned classification of a sample against the latched reference.
module cmp_classify
  import cmp_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] ref_val,
  output cmp_class_t        cls
);

  always_comb begin
    cls = EQ;
    if (data > ref_val) begin
      cls = HI;
    end else if (data < ref_val) begin
      cls = LO;
    end
  end

endmodule

// File: rtl/compare_window_tracker.sv
// Collects a window of samples, counts higher/less/equal against a latched reference,
// tracks min/max, and presents the results over a valid/ready handshake.
module compare_window_tracker
  import cmp_pkg::*;
#(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] REF,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CNT_W-1:0]  CNT_HIGHER,
  output logic [CNT_W-1:0]  CNT_LESS,
  output logic [CNT_W-1:0]  CNT_EQUAL,
  output logic [DATA_W-1:0] MIN_VAL,
  output logic [DATA_W-1:0] MAX_VAL,
  output logic              BUSY
);

  localparam int unsigned SW = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);

  cmp_state_t        state_q, state_d;
  logic [DATA_W-1:0] ref_q, ref_d;
  logic [SW-1:0]     smp_q, smp_d;
  logic [CNT_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0]  lo_q, lo_d;
  logic [CNT_W-1:0]  eq_q, eq_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  cmp_class_t        cls;
  logic              accept;

  cmp_classify u_classify (
    .data    (IN_DATA),
    .ref_val (ref_q),
    .cls     (cls)
  );

  // Handshake outputs come from registered state only.
  assign IN_READY  = (state_q == COLLECT);
  assign OUT_VALID = (state_q == DONE);
  assign BUSY      = (state_q != IDLE);
  assign accept    = IN_READY && IN_VALID;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    smp_d   = smp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    eq_d    = eq_q;
    min_d   = min_q;
    max_d   = max_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          ref_d   = REF;
          smp_d   = '0;
          hi_d    = '0;
          lo_d    = '0;
          eq_d    = '0;
          min_d   = MIN_INIT;
          max_d   = MAX_INIT;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          unique case (cls)
            HI:      hi_d = hi_q + CNT_W'(1);
            LO:      lo_d = lo_q + CNT_W'(1);
            default: eq_d = eq_q + CNT_W'(1);
          endcase
          if (IN_DATA < min_q) min_d = IN_DATA;
          if (IN_DATA > max_q) max_d = IN_DATA;
          smp_d = smp_q + SW'(1);
          if (smp_q == SW'(WINDOW - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ref_q   <= '0;
      smp_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      eq_q    <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      smp_q   <= smp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      eq_q    <= eq_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign CNT_HIGHER = hi_q;
  assign CNT_LESS   = lo_q;
  assign CNT_EQUAL  = eq_q;
  assign MIN_VAL    = min_q;
  assign MAX_VAL    = max_q;

endmodule

// File: tb/tb_compare_window_tracker.sv
// Scoreboard bench: directed windows on a WINDOW=4 and a WINDOW=1 instance.
module tb_compare_window_tracker;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] eq;
    logic [3:0] mn;
    logic [3:0] mx;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st4, iv4, ir4, ov4, ordy4, bz4;
  logic [3:0] ref4, d4, mn4, mx4;
  logic [7:0] hi4, lo4, eq4;
  logic       st1, iv1, ir1, ov1, ordy1, bz1;
  logic [3:0] ref1, d1, mn1, mx1;
  logic [7:0] hi1, lo1, eq1;

  int n_chk  = 0;
  int n_fail = 0;
  res_t q4[$];
  res_t q1[$];
  res_t e4, a4, e1, a1;

  compare_window_tracker #(.WINDOW(4), .CNT_W(8)) dut4 (
    .CLK(clk), .RST(rst), .START(st4), .REF(ref4), .IN_VALID(iv4), .IN_DATA(d4),
    .IN_READY(ir4), .OUT_VALID(ov4), .OUT_READY(ordy4), .CNT_HIGHER(hi4), .CNT_LESS(lo4),
    .CNT_EQUAL(eq4), .MIN_VAL(mn4), .MAX_VAL(mx4), .BUSY(bz4)
  );

  compare_window_tracker #(.WINDOW(1), .CNT_W(8)) dut1 (
    .CLK(clk), .RST(rst), .START(st1), .REF(ref1), .IN_VALID(iv1), .IN_DATA(d1),
    .IN_READY(ir1), .OUT_VALID(ov1), .OUT_READY(ordy1), .CNT_HIGHER(hi1), .CNT_LESS(lo1),
    .CNT_EQUAL(eq1), .MIN_VAL(mn1), .MAX_VAL(mx1), .BUSY(bz1)
  );

  // Monitors: pop expected results on each output handshake.
  always @(negedge clk) begin
    if (ov4 && ordy4) begin
      n_chk++;
      a4 = '{hi: hi4, lo: lo4, eq: eq4, mn: mn4, mx: mx4};
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL out4_unexpected: got %h, expected no result", a4);
      end else begin
        e4 = q4.pop_front();
        if (a4 !== e4) begin
          n_fail++;
          $display("FAIL out4_result: got %h, expected %h", a4, e4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ov1 && ordy1) begin
      n_chk++;
      a1 = '{hi: hi1, lo: lo1, eq: eq1, mn: mn1, mx: mx1};
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL out1_unexpected: got %h, expected no result", a1);
      end else begin
        e1 = q1.pop_front();
        if (a1 !== e1) begin
          n_fail++;
          $display("FAIL out1_result: got %h, expected %h", a1, e1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start4(input logic [3:0] r);
    st4 = 1'b1; ref4 = r;
    tick();
    st4 = 1'b0; ref4 = 4'hA;
  endtask

  task automatic send4(input logic [3:0] d);
    iv4 = 1'b1; d4 = d;
    tick();
    iv4 = 1'b0; d4 = 4'h0;
  endtask

  task automatic handshake4();
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
  endtask

  initial begin
    logic [3:0] s0 [4];
    logic       vpat [7];
    logic [3:0] dpat [7];
    rst = 1'b1;
    st4 = 0; ref4 = 0; iv4 = 0; d4 = 0; ordy4 = 0;
    st1 = 0; ref1 = 0; iv1 = 0; d1 = 0; ordy1 = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", ir4, 0);
    chk("rst_out_valid", ov4, 0);
    chk("rst_busy", bz4, 0);
    chk("rst_counts", {hi4, lo4, eq4}, 0);
    chk("rst_minmax", {mn4, mx4}, 0);

    // Basic window: REF=5, samples 3,5,9,5.
    q4.push_back('{hi: 1, lo: 1, eq: 2, mn: 3, mx: 9});
    start4(4'd5);
    chk("w1_in_ready", ir4, 1);
    chk("w1_busy", bz4, 1);
    s0 = '{4'd3, 4'd5, 4'd9, 4'd5};
    for (int i = 0; i < 4; i++) begin
      chk("w1_no_valid_early", ov4, 0);
      send4(s0[i]);
    end
    chk("w1_out_valid", ov4, 1);
    chk("w1_in_ready_done", ir4, 0);
    // START coincident with the handshake must be ignored.
    st4 = 1'b1; ref4 = 4'd2;
    handshake4();
    st4 = 1'b0;
    chk("w1_post_valid", ov4, 0);
    chk("w1_post_busy", bz4, 0);
    chk("w1_retained", {hi4, lo4, eq4, mn4, mx4}, {8'd1, 8'd1, 8'd2, 4'd3, 4'd9});

    // Boundaries on REF=0 and REF=15.
    q4.push_back('{hi: 2, lo: 0, eq: 2, mn: 0, mx: 15});
    start4(4'd0);
    s0 = '{4'd0, 4'd0, 4'd15, 4'd15};
    for (int i = 0; i < 4; i++) send4(s0[i]);
    handshake4();
    q4.push_back('{hi: 0, lo: 2, eq: 2, mn: 0, mx: 15});
    start4(4'd15);
    for (int i = 0; i < 4; i++) send4(s0[i]);
    handshake4();

    // Gapped IN_VALID; idle-cycle data must not be counted.
    q4.push_back('{hi: 1, lo: 1, eq: 2, mn: 2, mx: 12});
    start4(4'd8);
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    dpat = '{4'd8, 4'd0, 4'd15, 4'd2, 4'd12, 4'd1, 4'd8};
    for (int i = 0; i < 7; i++) begin
      iv4 = vpat[i]; d4 = dpat[i];
      tick();
      if (i == 5) chk("gap_not_done", ov4, 0);
    end
    chk("gap_done", ov4, 1);
    // Stall in DONE with IN_VALID high and a START pulse.
    iv4 = 1'b1; d4 = 4'd0;
    for (int i = 0; i < 10; i++) begin
      st4 = (i == 4); ref4 = 4'd1;
      tick();
      chk("stall_valid", ov4, 1);
      chk("stall_results", {hi4, lo4, eq4, mn4, mx4}, {8'd1, 8'd1, 8'd2, 4'd2, 4'd12});
    end
    st4 = 1'b0; iv4 = 1'b0;
    handshake4();
    chk("stall_idle", bz4, 0);
    chk("stall_retained", {hi4, lo4, eq4, mn4, mx4}, {8'd1, 8'd1, 8'd2, 4'd2, 4'd12});

    // Reset aborts a window; next window starts fresh.
    start4(4'd5);
    send4(4'd3);
    send4(4'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", ov4, 0);
    chk("abort_busy", bz4, 0);
    chk("abort_ready", ir4, 0);
    chk("abort_outputs", {hi4, lo4, eq4, mn4, mx4}, 0);
    q4.push_back('{hi: 0, lo: 0, eq: 4, mn: 5, mx: 5});
    start4(4'd5);
    for (int i = 0; i < 4; i++) send4(4'd5);
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;

    // WINDOW=1 instance.
    st1 = 1'b1; ref1 = 4'd7;
    tick();
    st1 = 1'b0; ref1 = 4'd0;
    chk("w1inst_not_valid", ov1, 0);
    q1.push_back('{hi: 0, lo: 0, eq: 1, mn: 7, mx: 7});
    iv1 = 1'b1; d1 = 4'd7;
    tick();
    iv1 = 1'b0; d1 = 4'd0;
    chk("w1inst_valid", ov1, 1);
    ordy1 = 1'b1;
    tick();
    ordy1 = 1'b0;
    chk("w1inst_idle", bz1, 0);

    for (int i = 0; i < 20 && (q4.size() + q1.size()) != 0; i++) tick();
    chk("scoreboard_drained", q4.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
